// File: rtl/fpu_ss_issue_buffer.sv
// In-order issue buffer between the offload interface and the FPU controller.
// Each entry tracks commit/kill state; killed heads drain without a consumer.
module fpu_ss_issue_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic [ID_W-1:0]            push_id_i,
    output logic                       pop_valid_o,
    input  logic                       pop_ready_i,
    output logic [DATA_W-1:0]          pop_data_o,
    output logic [ID_W-1:0]            pop_id_o,
    output logic                       pop_committed_o,
    input  logic                       commit_valid_i,
    input  logic [ID_W-1:0]            commit_id_i,
    input  logic                       commit_kill_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [ID_W-1:0]   r_id   [DEPTH];
    logic [DEPTH-1:0]  r_committed;
    logic [DEPTH-1:0]  r_killed;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W-1:0]  r_wptr;
    logic [CNT_W-1:0]  r_count;

    logic [DEPTH-1:0]  w_occupied;
    logic [DEPTH-1:0]  w_match;
    logic [PTR_W-1:0]  w_off;
    logic              w_push;
    logic              w_drain;
    logic              w_adv;
    logic              w_push_hit;

    assign count_o         = r_count;
    assign empty_o         = (r_count == '0);
    assign full_o          = (r_count == CNT_W'(DEPTH));
    assign push_ready_o    = ~full_o;
    assign pop_valid_o     = ~empty_o & ~r_killed[r_rptr];
    assign pop_data_o      = r_data[r_rptr];
    assign pop_id_o        = r_id[r_rptr];
    assign pop_committed_o = r_committed[r_rptr];

    assign w_push     = push_valid_i & push_ready_o;
    assign w_drain    = ~empty_o & r_killed[r_rptr];
    assign w_adv      = (pop_valid_o & pop_ready_i) | w_drain;
    assign w_push_hit = commit_valid_i & (commit_id_i == push_id_i);

    // An entry is live when its distance from the read pointer is below the count,
    // so commits to stale slots left behind by pops or flushes are ignored.
    always_comb begin
        w_occupied = '0;
        w_match    = '0;
        w_off      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off         = PTR_W'(i) - r_rptr;
            w_occupied[i] = CNT_W'(w_off) < r_count;
            w_match[i]    = w_occupied[i] & (r_id[i] == commit_id_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            if (rst_i) begin
                r_committed <= '0;
                r_killed    <= '0;
            end
        end else begin
            if (commit_valid_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_match[i]) begin
                        if (commit_kill_i) r_killed[i]    <= 1'b1;
                        else               r_committed[i] <= 1'b1;
                    end
                end
            end
            // The push slot is never occupied, so this write cannot clobber a commit above.
            if (w_push) begin
                r_data[r_wptr]      <= push_data_i;
                r_id[r_wptr]        <= push_id_i;
                r_committed[r_wptr] <= w_push_hit & ~commit_kill_i;
                r_killed[r_wptr]    <= w_push_hit & commit_kill_i;
                r_wptr              <= r_wptr + PTR_W'(1);
            end
            if (w_adv) r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_adv})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_ss_issue_buffer.sv
// Directed, table-driven bench for fpu_ss_issue_buffer (DEPTH=4).
// Each row drives one cycle of inputs and checks the state visible after that edge.
module tb_fpu_ss_issue_buffer;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              push_valid_i = 1'b0;
    logic              push_ready_o;
    logic [DATA_W-1:0] push_data_i = '0;
    logic [ID_W-1:0]   push_id_i = '0;
    logic              pop_valid_o;
    logic              pop_ready_i = 1'b0;
    logic [DATA_W-1:0] pop_data_o;
    logic [ID_W-1:0]   pop_id_o;
    logic              pop_committed_o;
    logic              commit_valid_i = 1'b0;
    logic [ID_W-1:0]   commit_id_i = '0;
    logic              commit_kill_i = 1'b0;
    logic              flush_i = 1'b0;
    logic [CNT_W-1:0]  count_o;
    logic              empty_o;
    logic              full_o;

    always #5 clk = ~clk;

    fpu_ss_issue_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
        .push_data_i(push_data_i), .push_id_i(push_id_i),
        .pop_valid_o(pop_valid_o), .pop_ready_i(pop_ready_i),
        .pop_data_o(pop_data_o), .pop_id_o(pop_id_o), .pop_committed_o(pop_committed_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .flush_i(flush_i), .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
    );

    typedef struct {
        bit       rst, flush, pv;
        int       pid;
        bit       pr, cv;
        int       cid;
        bit       ck;
        bit       e_pv;
        int       e_hid;
        bit       e_cm;
        int       e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    // Payload is derived from the ID so head data can be predicted from the expected ID.
    function automatic logic [DATA_W-1:0] pay(input int id);
        return 32'hC0DE_0000 | (id * 32'h0000_0101);
    endfunction

    task automatic v(input bit rst, flush, pv, input int pid, input bit pr, cv,
                     input int cid, input bit ck, input bit e_pv, input int e_hid,
                     input bit e_cm, input int e_cnt);
        vec_t r;
        r.rst = rst; r.flush = flush; r.pv = pv; r.pid = pid; r.pr = pr; r.cv = cv;
        r.cid = cid; r.ck = ck; r.e_pv = e_pv; r.e_hid = e_hid; r.e_cm = e_cm; r.e_cnt = e_cnt;
        vecs.push_back(r);
    endtask

    task automatic cmp(input string name, input int idx, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        rst_i          = r.rst;
        flush_i        = r.flush;
        push_valid_i   = r.pv;
        push_id_i      = ID_W'(r.pid);
        push_data_i    = pay(r.pid);
        pop_ready_i    = r.pr;
        commit_valid_i = r.cv;
        commit_id_i    = ID_W'(r.cid);
        commit_kill_i  = r.ck;
    endtask

    task automatic check_row(input int idx, input vec_t r);
        cmp("count", idx, count_o, r.e_cnt);
        cmp("empty", idx, empty_o, r.e_cnt == 0);
        cmp("full", idx, full_o, r.e_cnt == DEPTH);
        cmp("push_ready", idx, push_ready_o, r.e_cnt != DEPTH);
        cmp("pop_valid", idx, pop_valid_o, r.e_pv);
        if (r.e_pv) begin
            cmp("pop_id", idx, pop_id_o, r.e_hid);
            cmp("pop_data", idx, pop_data_o, pay(r.e_hid));
            cmp("pop_committed", idx, pop_committed_o, r.e_cm);
        end
    endtask

    initial begin
        //  rst fl pv pid pr cv cid ck | pv hid cm cnt
        // reset state
        v(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        // fill to full, then a push with a pop is refused
        v(0, 0, 1, 1, 0, 0, 0, 0,   1, 1, 0, 1);
        v(0, 0, 1, 2, 0, 0, 0, 0,   1, 1, 0, 2);
        v(0, 0, 1, 3, 0, 0, 0, 0,   1, 1, 0, 3);
        v(0, 0, 1, 4, 0, 0, 0, 0,   1, 1, 0, 4);
        v(0, 0, 1, 5, 1, 0, 0, 0,   1, 2, 0, 3);
        v(0, 0, 0, 0, 1, 0, 0, 0,   1, 3, 0, 2);
        v(0, 0, 0, 0, 1, 0, 0, 0,   1, 4, 0, 1);
        v(0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0);
        // ordering across pointer wrap with continuous pop
        v(0, 0, 1, 0, 1, 0, 0, 0,   1, 0, 0, 1);
        v(0, 0, 1, 1, 1, 0, 0, 0,   1, 1, 0, 1);
        v(0, 0, 1, 2, 1, 0, 0, 0,   1, 2, 0, 1);
        v(0, 0, 1, 3, 1, 0, 0, 0,   1, 3, 0, 1);
        v(0, 0, 1, 4, 1, 0, 0, 0,   1, 4, 0, 1);
        v(0, 0, 1, 5, 1, 0, 0, 0,   1, 5, 0, 1);
        v(0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0);
        // kill at head drains one cycle later, then commit and unmatched commit
        v(0, 0, 1, 2, 0, 0, 0, 0,   1, 2, 0, 1);
        v(0, 0, 1, 3, 0, 0, 0, 0,   1, 2, 0, 2);
        v(0, 0, 1, 4, 0, 0, 0, 0,   1, 2, 0, 3);
        v(0, 0, 0, 0, 0, 1, 2, 1,   0, 0, 0, 3);
        v(0, 0, 0, 0, 0, 0, 0, 0,   1, 3, 0, 2);
        v(0, 0, 0, 0, 0, 1, 3, 0,   1, 3, 1, 2);
        v(0, 0, 0, 0, 0, 1, 9, 0,   1, 3, 1, 2);
        v(0, 0, 0, 0, 1, 0, 0, 0,   1, 4, 0, 1);
        v(0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0);
        // commit arriving with the push of the same ID
        v(0, 0, 1, 7, 0, 1, 7, 0,   1, 7, 1, 1);
        v(0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0);
        // kill of a middle entry keeps order and drains with pop_ready low
        v(0, 0, 1, 10, 0, 0, 0, 0,  1, 10, 0, 1);
        v(0, 0, 1, 11, 0, 0, 0, 0,  1, 10, 0, 2);
        v(0, 0, 1, 12, 0, 0, 0, 0,  1, 10, 0, 3);
        v(0, 0, 0, 0, 0, 1, 11, 1,  1, 10, 0, 3);
        v(0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 2);
        v(0, 0, 0, 0, 0, 0, 0, 0,   1, 12, 0, 1);
        v(0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0);
        // kill arriving with the push of the same ID
        v(0, 0, 1, 3, 0, 1, 3, 1,   0, 0, 0, 1);
        v(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        // flush beats a same-cycle push
        v(0, 0, 1, 1, 0, 0, 0, 0,   1, 1, 0, 1);
        v(0, 0, 1, 2, 0, 0, 0, 0,   1, 1, 0, 2);
        v(0, 0, 1, 3, 0, 0, 0, 0,   1, 1, 0, 3);
        v(0, 1, 1, 4, 0, 0, 0, 0,   0, 0, 0, 0);
        v(0, 0, 1, 5, 0, 0, 0, 0,   1, 5, 0, 1);
        v(0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0);
        // mid-operation reset, then a stale commit must not mark a new entry
        v(0, 0, 1, 6, 0, 0, 0, 0,   1, 6, 0, 1);
        v(0, 0, 1, 8, 0, 0, 0, 0,   1, 6, 0, 2);
        v(1, 0, 1, 9, 0, 0, 0, 0,   0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 1, 8, 0,   0, 0, 0, 0);
        v(0, 0, 1, 8, 0, 0, 0, 0,   1, 8, 0, 1);
        v(0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_row(i, vecs[i]);
        end

        // No fall-through: a push into an empty buffer is invisible before the edge.
        push_valid_i = 1'b1; push_id_i = 4'd13; push_data_i = pay(13);
        pop_ready_i = 1'b1; commit_valid_i = 1'b0; rst_i = 1'b0; flush_i = 1'b0;
        #1;
        cmp("nofall_pop_valid", -1, pop_valid_o, 0);
        cmp("nofall_empty", -1, empty_o, 1);
        @(posedge clk);
        #1;
        push_valid_i = 1'b0;
        cmp("nofall_after_pop_valid", -1, pop_valid_o, 1);
        cmp("nofall_after_id", -1, pop_id_o, 13);
        @(posedge clk);
        #1;
        pop_ready_i = 1'b0;
        cmp("nofall_drained_count", -1, count_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fpu_ss_issue_buffer.md
FPU_SS_ISSUE_BUFFER -- requirements
Module: fpu_ss_issue_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries; power of two, at least 2.
REQ-002 SHALL have parameter DATA_W, default 32, width of the instruction payload.
REQ-003 SHALL have parameter ID_W, default 4, width of the offload ID.
REQ-004 SHALL have ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- push_valid_i  in  1  issue side offers an entry.
- push_ready_o  out  1  buffer accepts an entry.
- push_data_i  in  DATA_W  instruction payload.
- push_id_i  in  ID_W  offload ID.
- pop_valid_o  out  1  head entry is presentable to the controller.
- pop_ready_i  in  1  controller consumes the head.
- pop_data_o  out  DATA_W  head payload.
- pop_id_o  out  ID_W  head ID.
- pop_committed_o  out  1  head has received a non-kill commit.
- commit_valid_i  in  1  commit event.
- commit_id_i  in  ID_W  ID being committed or killed.
- commit_kill_i  in  1  commit event is a kill.
- flush_i  in  1  discard all entries.
- count_o  out  $clog2(DEPTH+1)  occupied entries, including killed-not-yet-drained entries.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == DEPTH.

Function
REQ-005 SHALL store entries in FIFO order in a circular array with read/write pointers; both pointers wrap from DEPTH-1 to 0.
REQ-006 SHALL hold per-entry state: payload, ID, committed bit, killed bit.
REQ-007 SHALL drive push_ready_o = ~full_o; a same-cycle pop SHALL NOT make room for a push when full.
REQ-008 SHALL write an entry on push_valid_i & push_ready_o, with committed and killed bits cleared, unless REQ-011 applies.
REQ-009 SHALL make a pushed entry visible at the head no earlier than the next cycle; there is no fall-through path.
REQ-010 SHALL, on commit_valid_i, set committed (kill=0) or killed (kill=1) on every occupied entry whose ID equals commit_id_i; a commit whose ID matches no entry SHALL be ignored.
REQ-011 SHALL apply a commit whose ID matches push_id_i in the same cycle to the entry being pushed.
REQ-012 SHALL drive pop_valid_o = ~empty_o & ~head.killed; pop_data_o, pop_id_o and pop_committed_o come combinationally from the head entry.
REQ-013 SHALL advance the read pointer on pop_valid_o & pop_ready_i.
REQ-014 SHALL auto-drain a killed head entry: advance the read pointer one entry per cycle, independent of pop_ready_i.
REQ-015 SHALL keep count_o unchanged on a simultaneous push and pop/drain, increment it on push only, and decrement it on pop/drain only.
REQ-016 SHALL, on flush_i, zero both pointers and count_o the next cycle; flush SHALL take priority over a same-cycle push, pop or commit.
REQ-017 SHALL ensure commit and kill bits never alter payload or ID, and that a kill never reorders entries.

Reset
REQ-018 SHALL, with rst_i high at a clock edge, clear pointers, count and all committed/killed bits; payload storage need not be reset.
REQ-019 SHALL hold these output values during and after reset: pop_valid_o=0, empty_o=1, full_o=0, count_o=0, push_ready_o=1.
REQ-020 SHALL treat reset asserted mid-operation like flush_i; entries pushed in that cycle are discarded.

Verification
REQ-021 SHALL be verified with fill-to-full: push IDs 1,2,3,4 with pop_ready_i=0 -> count_o=4, full_o=1, push_ready_o=0; a fifth push with simultaneous pop is rejected.
REQ-022 SHALL be verified with ordering and wrap: push 6 entries (IDs 0..5) while popping continuously -> pop_id_o sequence 0..5 and correct payloads across pointer wrap.
REQ-023 SHALL be verified with kill drain: buffer holds IDs 2,3,4, kill ID 2 -> next cycle pop_valid_o=0, one cycle later head ID 3 with pop_valid_o=1 and count_o=2.
REQ-024 SHALL be verified with same-cycle commit and push: push ID 7 with commit_valid_i=1, commit_id_i=7, kill=0 -> entry 7 reaches the head with pop_committed_o=1.
REQ-025 SHALL be verified with flush versus push: 3 entries held, flush_i=1 together with push_valid_i=1 -> next cycle count_o=0, empty_o=1, pop_valid_o=0.
REQ-026 SHALL be verified with mid-operation reset: rst_i=1 with 2 entries held -> next cycle count_o=0, push_ready_o=1, and a later commit on a stale ID has no effect.
